// File: rtl/rmsnorm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rmsnorm_pkg
// Purpose  : Shared FSM state encoding and buffer read latency for the
//            RMSNorm sequencing controller.
// Revision : 1.0
// ============================================================================
package rmsnorm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACCUM = 3'd1,
    ST_DRAIN = 3'd2,
    ST_RSQRT = 3'd3,
    ST_NORM  = 3'd4,
    ST_DONE  = 3'd5
  } rmsnorm_state_e;

  // Buffer read data trails rd_en by this many cycles.
  localparam int RMSNORM_RD_LAT = 1;

endpackage
`default_nettype wire

// File: rtl/rmsnorm_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : rmsnorm_addr_gen
// Purpose  : Base/length latch, element index and wrapping read address,
//            shared by both read passes (restart rewinds to the base).
// Revision : 1.0
// ============================================================================
module rmsnorm_addr_gen #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              restart,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base_in,
  input  logic [ADDR_W:0]   len_in,
  output logic [ADDR_W-1:0] addr,
  output logic              more,
  output logic              last
);

  localparam logic [ADDR_W:0]   c_cnt_one  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);

  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base <= '0;
      r_len  <= '0;
      r_addr <= '0;
      r_idx  <= '0;
    end else if (load) begin
      r_base <= base_in;
      r_len  <= len_in;
      r_addr <= base_in;
      r_idx  <= '0;
    end else if (restart) begin
      r_addr <= r_base;
      r_idx  <= '0;
    end else if (advance) begin
      // ADDR_W-bit increment wraps the address modulo the buffer size
      r_addr <= r_addr + c_addr_one;
      r_idx  <= r_idx + c_cnt_one;
    end
  end

  assign addr = r_addr;
  assign more = (r_idx != r_len);
  assign last = ((r_idx + c_cnt_one) == r_len);

endmodule
`default_nettype wire

// File: rtl/rmsnorm_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rmsnorm_seq_ctrl
// Purpose  : Two-pass RMSNorm sequencer: accumulate pass, rsqrt handshake,
//            back-pressured scale pass. Optional RMSNORM_CTRL_PERF_EN builds
//            a saturating per-job cycle counter on perf_cycles.
// Revision : 1.0
// ============================================================================
module rmsnorm_seq_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              rsqrt_req,
  input  logic              rsqrt_ack,
  output logic              norm_valid,
  input  logic              norm_ready,
  output logic [31:0]       perf_cycles
);

  import rmsnorm_pkg::*;

  rmsnorm_state_e r_state;
  rmsnorm_state_e w_state_nxt;

  logic r_busy, r_done, r_rd_en_p1, r_acc_clr, r_rsqrt_req, r_norm_valid;
  logic w_busy_nxt, w_done_nxt, w_rd_p1_nxt, w_acc_clr_nxt, w_req_nxt;
  logic w_load, w_restart, w_advance;
  logic w_more, w_last, w_norm_rd, w_norm_hs;
  logic [ADDR_W-1:0] w_addr;

  logic [RMSNORM_RD_LAT-1:0] r_acc_pipe;
  logic [RMSNORM_RD_LAT:0]   w_acc_shift;

  rmsnorm_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (w_load),
    .restart (w_restart),
    .advance (w_advance),
    .base_in (base),
    .len_in  (len),
    .addr    (w_addr),
    .more    (w_more),
    .last    (w_last)
  );

  // Scale-pass reads are gated by norm_ready in the same cycle so a stalled
  // element is never overwritten at the buffer output.
  assign w_norm_rd = (r_state == ST_NORM) && w_more && (!r_norm_valid || norm_ready);
  assign w_norm_hs = r_norm_valid && norm_ready;

  always_comb begin
    w_state_nxt   = r_state;
    w_busy_nxt    = 1'b1;
    w_done_nxt    = 1'b0;
    w_rd_p1_nxt   = 1'b0;
    w_acc_clr_nxt = 1'b0;
    w_req_nxt     = 1'b0;
    w_load        = 1'b0;
    w_restart     = 1'b0;
    w_advance     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_busy_nxt = 1'b0;
        if (start) begin
          w_load     = 1'b1;
          w_busy_nxt = 1'b1;
          if (len != '0) begin
            w_state_nxt   = ST_ACCUM;
            w_rd_p1_nxt   = 1'b1;
            w_acc_clr_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      ST_ACCUM: begin
        w_advance = 1'b1;
        if (w_last) w_state_nxt = ST_DRAIN;
        else        w_rd_p1_nxt = 1'b1;
      end
      ST_DRAIN: begin
        w_state_nxt = ST_RSQRT;
        w_req_nxt   = 1'b1;
      end
      ST_RSQRT: begin
        if (rsqrt_ack) begin
          w_state_nxt = ST_NORM;
          w_restart   = 1'b1;
        end else begin
          w_req_nxt = 1'b1;
        end
      end
      ST_NORM: begin
        w_advance = w_norm_rd;
        // With no reads left, the element on the output is the final one
        if (w_norm_hs && !w_more) begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign w_acc_shift = {r_acc_pipe, r_rd_en_p1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_rd_en_p1   <= 1'b0;
      r_acc_clr    <= 1'b0;
      r_rsqrt_req  <= 1'b0;
      r_norm_valid <= 1'b0;
      r_acc_pipe   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_rd_en_p1  <= w_rd_p1_nxt;
      r_acc_clr   <= w_acc_clr_nxt;
      r_rsqrt_req <= w_req_nxt;
      r_acc_pipe  <= w_acc_shift[RMSNORM_RD_LAT-1:0];
      if (r_state != ST_NORM) r_norm_valid <= 1'b0;
      else if (w_norm_rd)     r_norm_valid <= 1'b1;
      else if (norm_ready)    r_norm_valid <= 1'b0;
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign rd_en      = r_rd_en_p1 | w_norm_rd;
  assign rd_addr    = w_addr;
  assign acc_clr    = r_acc_clr;
  assign acc_en     = r_acc_pipe[RMSNORM_RD_LAT-1];
  assign rsqrt_req  = r_rsqrt_req;
  assign norm_valid = r_norm_valid;

`ifdef RMSNORM_CTRL_PERF_EN
  logic [31:0] r_perf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf <= '0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_perf <= '0;
    end else if ((r_state != ST_IDLE) && (r_perf != '1)) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign perf_cycles = r_perf;
`else
  assign perf_cycles = 32'd0;
`endif

endmodule
`default_nettype wire
